// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write port arbiter with load tag FIFO, skid register and hazard detect
module wb_port_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [3:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_issue,
  input  logic [3:0]  ld_rd,
  input  logic [3:0]  ld_mask,
  output logic        ld_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic [3:0]  rs1,
  input  logic [3:0]  rs2,
  output logic        src_busy,
  output logic        n_stall,
  output logic        rf_we,
  output logic [3:0]  rf_rd,
  output logic [31:0] rf_wdata,
  output logic        err_underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [3:0]       q_rd   [DEPTH];
  logic [3:0]       q_mask [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [DEPTH-1:0] entry_valid;

  logic             skid_valid;
  logic [3:0]       skid_rd;
  logic [31:0]      skid_data;

  logic             push;
  logic             pop;
  logic [31:0]      pop_data;
  logic             rs1_nz;
  logic             rs2_nz;

  // ld_ready looks only at the current occupancy; a pop in the same cycle does not open a slot
  assign ld_ready = (count < CW'(DEPTH));
  assign push     = ld_issue && ld_ready;
  assign pop      = mem_rvalid && (count != '0);
  assign rs1_nz   = (rs1 != 4'd0);
  assign rs2_nz   = (rs2 != 4'd0);

  // Keep only the enabled byte lanes of the returned word, in place
  always_comb begin
    pop_data = '0;
    for (int b = 0; b < 4; b++) begin
      pop_data[8*b +: 8] = q_mask[rd_ptr][b] ? mem_rdata[8*b +: 8] : 8'h00;
    end
  end

  // An entry is live when its distance from the read pointer is below the count
  always_comb begin
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_valid[i] = ({1'b0, PW'(i) - rd_ptr} < count);
    end
  end

  // A nonzero source is busy if any pending writer (FIFO, skid, or current write) targets it
  always_comb begin
    src_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && ((rs1_nz && q_rd[i] == rs1) || (rs2_nz && q_rd[i] == rs2))) begin
        src_busy = 1'b1;
      end
    end
    if (skid_valid && ((rs1_nz && skid_rd == rs1) || (rs2_nz && skid_rd == rs2))) begin
      src_busy = 1'b1;
    end
    if (rf_we && ((rs1_nz && rf_rd == rs1) || (rs2_nz && rf_rd == rs2))) begin
      src_busy = 1'b1;
    end
  end

  // Hold the pipeline while the skid is occupied, a source is pending, or a load cannot be taken
  assign n_stall = !skid_valid && !src_busy && !(ld_issue && !ld_ready);

  // FIFO payload storage; contents are meaningless outside the live window, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr]   <= ld_rd;
      q_mask[wr_ptr] <= ld_mask;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Write-port arbitration: load return first, then the skid, then a fresh ALU result
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we         <= 1'b0;
      rf_rd         <= 4'd0;
      rf_wdata      <= 32'd0;
      skid_valid    <= 1'b0;
      skid_rd       <= 4'd0;
      skid_data     <= 32'd0;
      err_underflow <= 1'b0;
    end else begin
      if (mem_rvalid && count == '0) err_underflow <= 1'b1;
      if (pop) begin
        rf_we    <= (q_rd[rd_ptr] != 4'd0);
        rf_rd    <= q_rd[rd_ptr];
        rf_wdata <= pop_data;
        if (alu_valid && !skid_valid) begin
          skid_valid <= 1'b1;
          skid_rd    <= alu_rd;
          skid_data  <= alu_data;
        end
      end else if (skid_valid) begin
        rf_we      <= (skid_rd != 4'd0);
        rf_rd      <= skid_rd;
        rf_wdata   <= skid_data;
        skid_valid <= 1'b0;
      end else if (alu_valid) begin
        rf_we    <= (alu_rd != 4'd0);
        rf_rd    <= alu_rd;
        rf_wdata <= alu_data;
      end else begin
        rf_we <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [3:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_issue;
  logic [3:0]  ld_rd;
  logic [3:0]  ld_mask;
  logic        ld_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [3:0]  rs1;
  logic [3:0]  rs2;
  logic        src_busy;
  logic        n_stall;
  logic        rf_we;
  logic [3:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        err_underflow;

  wb_port_arbiter #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .alu_valid     (alu_valid),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .ld_issue      (ld_issue),
    .ld_rd         (ld_rd),
    .ld_mask       (ld_mask),
    .ld_ready      (ld_ready),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .rs1           (rs1),
    .rs2           (rs2),
    .src_busy      (src_busy),
    .n_stall       (n_stall),
    .rf_we         (rf_we),
    .rf_rd         (rf_rd),
    .rf_wdata      (rf_wdata),
    .err_underflow (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] rd;
    logic [3:0] mask;
  } ld_t;

  // Reference model: pending loads in issue order, optional parked ALU result, last write
  ld_t         q[$];
  logic        m_skid_v;
  logic [3:0]  m_skid_rd;
  logic [31:0] m_skid_data;
  logic        m_we;
  logic [3:0]  m_rd;
  logic [31:0] m_wdata;
  logic        m_err;

  logic        s_ready;
  logic        s_busy;
  logic        s_nstall;

  int n_checks;
  int n_errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] apply_mask(input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r;
    r = 32'd0;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic pending(input logic [3:0] r);
    if (r == 4'd0) return 1'b0;
    foreach (q[i]) if (q[i].rd == r) return 1'b1;
    if (m_skid_v && m_skid_rd == r) return 1'b1;
    if (m_we && m_rd == r) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: drive inputs, check combinational outputs, clock, advance model, check registers
  task automatic cycle(input logic r, input logic a_v, input logic [3:0] a_rd, input logic [31:0] a_d,
                       input logic i_v, input logic [3:0] i_rd, input logic [3:0] i_mask,
                       input logic rv, input logic [31:0] rdata,
                       input logic [3:0] s1, input logic [3:0] s2);
    logic e_ready;
    logic e_busy;
    logic e_nstall;
    ld_t  e;
    rst = r; alu_valid = a_v; alu_rd = a_rd; alu_data = a_d;
    ld_issue = i_v; ld_rd = i_rd; ld_mask = i_mask;
    mem_rvalid = rv; mem_rdata = rdata; rs1 = s1; rs2 = s2;
    #3;
    e_ready  = (q.size() < DEPTH);
    e_busy   = pending(s1) || pending(s2);
    e_nstall = !m_skid_v && !e_busy && !(i_v && !e_ready);
    s_ready  = ld_ready;
    s_busy   = src_busy;
    s_nstall = n_stall;
    if (!r) begin
      chk("ld_ready", 32'(ld_ready), 32'(e_ready));
      chk("src_busy", 32'(src_busy), 32'(e_busy));
      chk("n_stall", 32'(n_stall), 32'(e_nstall));
    end
    @(posedge clk);
    if (r) begin
      q.delete();
      m_skid_v = 1'b0; m_we = 1'b0; m_rd = 4'd0; m_wdata = 32'd0; m_err = 1'b0;
    end else begin
      if (rv && q.size() == 0) m_err = 1'b1;
      if (rv && q.size() != 0) begin
        e = q.pop_front();
        m_we = (e.rd != 4'd0); m_rd = e.rd; m_wdata = apply_mask(rdata, e.mask);
        if (a_v && !m_skid_v) begin
          m_skid_v = 1'b1; m_skid_rd = a_rd; m_skid_data = a_d;
        end
      end else if (m_skid_v) begin
        m_we = (m_skid_rd != 4'd0); m_rd = m_skid_rd; m_wdata = m_skid_data; m_skid_v = 1'b0;
      end else if (a_v) begin
        m_we = (a_rd != 4'd0); m_rd = a_rd; m_wdata = a_d;
      end else begin
        m_we = 1'b0;
      end
      if (i_v && e_ready) q.push_back('{rd: i_rd, mask: i_mask});
    end
    #1;
    chk("rf_we", 32'(rf_we), 32'(m_we));
    chk("err_underflow", 32'(err_underflow), 32'(m_err));
    if (m_we) begin
      chk("rf_rd", 32'(rf_rd), 32'(m_rd));
      chk("rf_wdata", rf_wdata, m_wdata);
    end
  endtask

  task automatic idle(input logic [3:0] s1);
    cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0, 1'b0, 32'd0, s1, 4'd0);
  endtask

  initial begin
    logic [3:0] order [6];
    n_checks = 0;
    n_errors = 0;
    m_skid_v = 1'b0; m_skid_rd = 4'd0; m_skid_data = 32'd0;
    m_we = 1'b0; m_rd = 4'd0; m_wdata = 32'd0; m_err = 1'b0;
    rst = 1'b1; alu_valid = 1'b0; alu_rd = 4'd0; alu_data = 32'd0;
    ld_issue = 1'b0; ld_rd = 4'd0; ld_mask = 4'd0;
    mem_rvalid = 1'b0; mem_rdata = 32'd0; rs1 = 4'd0; rs2 = 4'd0;
    @(posedge clk); #1;

    // Reset held two cycles with every input active
    cycle(1'b1, 1'b1, 4'd3, 32'h1234, 1'b1, 4'd5, 4'hF, 1'b1, 32'hFFFF_FFFF, 4'd5, 4'd3);
    cycle(1'b1, 1'b1, 4'd3, 32'h1234, 1'b1, 4'd5, 4'hF, 1'b1, 32'hFFFF_FFFF, 4'd5, 4'd3);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_rf_rd", 32'(rf_rd), 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    chk("rst_err", 32'(err_underflow), 32'd0);
    idle(4'd0);
    chk("rst_ld_ready", 32'(s_ready), 32'd1);
    chk("rst_n_stall", 32'(s_nstall), 32'd1);

    // Masked load: only the low two bytes survive
    cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 4'b0011, 1'b0, 32'd0, 4'd5, 4'd0);
    idle(4'd5);
    chk("ml_busy_pending", 32'(s_busy), 32'd1);
    cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0, 1'b1, 32'hDEAD_BEEF, 4'd5, 4'd0);
    chk("ml_we", 32'(rf_we), 32'd1);
    chk("ml_rd", 32'(rf_rd), 32'd5);
    chk("ml_wdata", rf_wdata, 32'h0000_BEEF);
    idle(4'd5);
    chk("ml_busy_write", 32'(s_busy), 32'd1);
    idle(4'd5);
    chk("ml_busy_clear", 32'(s_busy), 32'd0);

    // Port conflict: load return wins, ALU result parks in the skid
    cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd4, 4'hF, 1'b0, 32'd0, 4'd0, 4'd0);
    idle(4'd0);
    cycle(1'b0, 1'b1, 4'd3, 32'd7, 1'b0, 4'd0, 4'd0, 1'b1, 32'hA5A5_0001, 4'd0, 4'd0);
    chk("pc_first_rd", 32'(rf_rd), 32'd4);
    idle(4'd0);
    chk("pc_stall_skid", 32'(s_nstall), 32'd0);
    chk("pc_second_rd", 32'(rf_rd), 32'd3);
    chk("pc_second_data", rf_wdata, 32'd7);
    idle(4'd0);
    chk("pc_stall_release", 32'(s_nstall), 32'd1);

    // Fill, drop a fifth issue, drain across pointer wrap including a full push+pop
    for (int k = 1; k <= 4; k++)
      cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'(k), 4'hF, 1'b0, 32'd0, 4'd0, 4'd0);
    cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd9, 4'hF, 1'b0, 32'd0, 4'd0, 4'd0);
    chk("full_ready", 32'(s_ready), 32'd0);
    chk("full_stall", 32'(s_nstall), 32'd0);
    order[0] = 4'd1; order[1] = 4'd2; order[2] = 4'd3;
    order[3] = 4'd4; order[4] = 4'd6; order[5] = 4'd7;
    for (int k = 0; k < 2; k++) begin
      cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0, 1'b1, 32'h1111_0000 + 32'(k), 4'd0, 4'd0);
      chk("wrap_order", 32'(rf_rd), 32'(order[k]));
    end
    cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd6, 4'hF, 1'b0, 32'd0, 4'd0, 4'd0);
    cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd7, 4'hF, 1'b0, 32'd0, 4'd0, 4'd0);
    cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd10, 4'hF, 1'b1, 32'h1111_0002, 4'd0, 4'd0);
    chk("wrap_order", 32'(rf_rd), 32'(order[2]));
    idle(4'd10);
    chk("full_pushpop_ready", 32'(s_ready), 32'd1);
    chk("full_push_dropped", 32'(s_busy), 32'd0);
    for (int k = 3; k < 6; k++) begin
      cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0, 1'b1, 32'h2222_0000 + 32'(k), 4'd0, 4'd0);
      chk("wrap_order", 32'(rf_rd), 32'(order[k]));
    end

    // Register 0 is never written and never busy
    cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd0, 4'hF, 1'b0, 32'd0, 4'd0, 4'd0);
    idle(4'd0);
    chk("r0_busy", 32'(s_busy), 32'd0);
    cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0, 1'b1, 32'hCAFE_F00D, 4'd0, 4'd0);
    chk("r0_load_we", 32'(rf_we), 32'd0);
    cycle(1'b0, 1'b1, 4'd0, 32'd5, 1'b0, 4'd0, 4'd0, 1'b0, 32'd0, 4'd0, 4'd0);
    chk("r0_alu_we", 32'(rf_we), 32'd0);

    // Underflow, including a same-cycle issue that must stay pending
    cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd8, 4'hF, 1'b1, 32'hFFFF_FFFF, 4'd8, 4'd0);
    chk("uf_err", 32'(err_underflow), 32'd1);
    chk("uf_no_write", 32'(rf_we), 32'd0);
    idle(4'd8);
    chk("uf_pending", 32'(s_busy), 32'd1);
    cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0, 1'b1, 32'h0808_0808, 4'd0, 4'd0);
    chk("uf_late_rd", 32'(rf_rd), 32'd8);
    chk("uf_sticky", 32'(err_underflow), 32'd1);

    // Randomized traffic against the model, with occasional resets
    for (int n = 0; n < 600; n++) begin
      logic r;
      logic a_v;
      logic rv;
      r   = ($urandom_range(0, 79) == 0);
      a_v = ($urandom_range(0, 2) == 0) && !m_skid_v;
      rv  = (q.size() != 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 24) == 0);
      cycle(r, a_v, 4'($urandom), $urandom, 1'($urandom), 4'($urandom), 4'($urandom),
            rv, $urandom, 4'($urandom), 4'($urandom));
    end

    // Reset mid-operation discards pending loads and the error flag
    cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd2, 4'hF, 1'b1, 32'd0, 4'd0, 4'd0);
    cycle(1'b1, 1'b1, 4'd3, 32'd1, 1'b0, 4'd0, 4'd0, 1'b0, 32'd0, 4'd0, 4'd0);
    chk("midrst_err", 32'(err_underflow), 32'd0);
    idle(4'd2);
    chk("midrst_busy", 32'(s_busy), 32'd0);
    chk("midrst_nstall", 32'(s_nstall), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
